// File: rtl/pipelined_compare.sv
// Pipelined magnitude/equality comparator: signed or unsigned, run-time LT/LE/EQ/NE select.
// Latency STAGES = WIDTH/CHUNK cycles; one result per cycle while O_READY is high.
// Backpressure: the whole pipe freezes while O_VALID && !O_READY, and I_READY drops with it.
//
// Ports: CLK/RESETN (sync active-low), I_VALID/I_READY/I0/I1/SIGNED/OP on the input side,
//        O_VALID/O_READY/O/O_LT/O_EQ on the result side.
// WIDTH must be a multiple of CHUNK.
module pipelined_compare #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             SIGNED,
    input  logic [1:0]       OP,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             O,
    output logic             O_LT,
    output logic             O_EQ
);
    localparam int STAGES = WIDTH / CHUNK;

    logic en;
    logic [WIDTH-1:0] a_entry;
    logic [WIDTH-1:0] b_entry;

    // A single global enable: every stage advances or holds together.
    assign en      = !O_VALID || O_READY;
    assign I_READY = en;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
    always_comb begin
        a_entry            = I0;
        b_entry            = I1;
        a_entry[WIDTH-1]   = I0[WIDTH-1] ^ SIGNED;
        b_entry[WIDTH-1]   = I1[WIDTH-1] ^ SIGNED;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage registers. a_q/b_q hold the not-yet-consumed upper chunks,
        // shifted down so that the next stage always works on bits [CHUNK-1:0].
        logic             v_q;
        logic [1:0]       op_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic             c_q;
        logic             e_q;

        logic             v_in;
        logic [1:0]       op_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic             c_in;
        logic             e_in;
        logic             c_out;
        logic [CHUNK-1:0] unused_diff;

        if (k == 0) begin : g_first
            assign v_in  = I_VALID;
            assign op_in = OP;
            assign a_in  = a_entry;
            assign b_in  = b_entry;
            assign c_in  = 1'b1;   // the +1 of the two's-complement subtract
            assign e_in  = 1'b1;
        end else begin : g_next
            assign v_in  = g_stage[k-1].v_q;
            assign op_in = g_stage[k-1].op_q;
            assign a_in  = g_stage[k-1].a_q;
            assign b_in  = g_stage[k-1].b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign e_in  = g_stage[k-1].e_q;
        end

        // One carry-chain segment of a + ~b + cin; only the carry is needed.
        assign {c_out, unused_diff} = {1'b0, a_in[CHUNK-1:0]}
                                    + {1'b0, ~b_in[CHUNK-1:0]}
                                    + {{CHUNK{1'b0}}, c_in};

        always_ff @(posedge CLK) begin
            if (!RESETN) begin
                v_q  <= 1'b0;
                op_q <= 2'b00;
                a_q  <= '0;
                b_q  <= '0;
                c_q  <= 1'b1;
                e_q  <= 1'b0;
            end else if (en) begin
                v_q  <= v_in;
                op_q <= op_in;
                a_q  <= a_in >> CHUNK;
                b_q  <= b_in >> CHUNK;
                c_q  <= c_out;
                e_q  <= e_in && (a_in[CHUNK-1:0] == b_in[CHUNK-1:0]);
            end
        end
    end

    // The last stage's shifted operands are fully consumed.
    logic unused_tail;
    assign unused_tail = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].b_q};

    logic       last_v;
    logic [1:0] last_op;
    logic       lt_raw;
    logic       eq_raw;
    logic       sel;

    assign last_v  = g_stage[STAGES-1].v_q;
    assign last_op = g_stage[STAGES-1].op_q;
    // No final carry out of a + ~b + 1 means a borrow, i.e. a < b.
    assign lt_raw  = !g_stage[STAGES-1].c_q;
    assign eq_raw  = g_stage[STAGES-1].e_q;

    always_comb begin
        sel = 1'b0;
        case (last_op)
            2'b00:   sel = lt_raw;
            2'b01:   sel = lt_raw || eq_raw;
            2'b10:   sel = eq_raw;
            default: sel = !eq_raw;
        endcase
    end

    // Flags are qualified by valid so bubbles and reset present all-zero outputs.
    assign O_VALID = last_v;
    assign O       = last_v && sel;
    assign O_LT    = last_v && lt_raw;
    assign O_EQ    = last_v && eq_raw;

endmodule

// File: tb/tb_pipelined_compare.sv
// Self-checking bench for pipelined_compare (WIDTH=16, CHUNK=4).
// Directed boundary cases, random throughput, back-pressure and mid-flight reset,
// all scored against a behavioural compare model and an in-order queue.
module tb_pipelined_compare;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int LAT    = WIDTH / CHUNK;

    logic             CLK = 1'b0;
    logic             RESETN;
    logic             I_VALID;
    logic             I_READY;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             SIGNED;
    logic [1:0]       OP;
    logic             O_VALID;
    logic             O_READY;
    logic             O;
    logic             O_LT;
    logic             O_EQ;

    pipelined_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .I_VALID(I_VALID), .I_READY(I_READY), .I0(I0), .I1(I1),
        .SIGNED(SIGNED), .OP(OP),
        .O_VALID(O_VALID), .O_READY(O_READY), .O(O), .O_LT(O_LT), .O_EQ(O_EQ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [1:0]       op;
        int               cyc;
        bit               lat;
    } txn_t;

    txn_t     q[$];
    int       passed   = 0;
    int       total    = 0;
    int       cycle    = 0;
    int       npop     = 0;
    bit       lat_mode = 0;
    bit       held_vld = 0;
    logic [2:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        else
            passed++;
    endtask

    // Reference: ordinary signed/unsigned arithmetic compare, then OP select.
    function automatic logic [2:0] ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic s, input logic [1:0] op);
        logic lt, eq, o;
        if (s) lt = ($signed(a) < $signed(b));
        else   lt = (a < b);
        eq = (a == b);
        case (op)
            2'd0:    o = lt;
            2'd1:    o = lt | eq;
            2'd2:    o = eq;
            default: o = !eq;
        endcase
        return {o, lt, eq};
    endfunction

    // One clock cycle: drive at posedge+1, observe handshakes at the negedge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [1:0] op, input logic ordy);
        txn_t t;
        logic [2:0] e;
        I_VALID = iv; I0 = a; I1 = b; SIGNED = s; OP = op; O_READY = ordy;
        #4;
        if (held_vld) begin
            check("hold_valid", O_VALID, 1'b1);
            check("hold_flags", {O, O_LT, O_EQ}, held);
        end
        check("i_ready", I_READY, !(O_VALID && !O_READY));
        if (O_VALID && O_READY) begin
            if (q.size() == 0) begin
                check("stale_result", 1, 0);
            end else begin
                t = q.pop_front();
                e = ref_model(t.a, t.b, t.s, t.op);
                npop++;
                check("o",    O,    e[2]);
                check("o_lt", O_LT, e[1]);
                check("o_eq", O_EQ, e[0]);
                if (t.lat) check("latency", cycle - t.cyc, LAT);
            end
        end
        if (I_VALID && I_READY) begin
            t.a = a; t.b = b; t.s = s; t.op = op; t.cyc = cycle; t.lat = lat_mode;
            q.push_back(t);
        end
        held_vld = O_VALID && !O_READY;
        held     = {O, O_LT, O_EQ};
        @(posedge CLK); #1;
        cycle++;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (q.size() != 0 && n < max_cycles) begin
            step(1'b0, '0, '0, 1'b0, 2'd0, 1'b1);
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic all_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        for (int op = 0; op < 4; op++) step(1'b1, a, b, s, op[1:0], 1'b1);
    endtask

    initial begin
        int start_pop;
        RESETN = 1'b0; I_VALID = 1'b0; I0 = '0; I1 = '0; SIGNED = 1'b0; OP = 2'd0; O_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_o_valid", O_VALID, 1'b0);
        check("rst_o",       O,       1'b0);
        check("rst_o_lt",    O_LT,    1'b0);
        check("rst_o_eq",    O_EQ,    1'b0);
        check("rst_i_ready", I_READY, 1'b1);
        RESETN = 1'b1;

        // Basic unsigned LT with latency, isolated.
        lat_mode = 1;
        step(1'b1, 16'd3, 16'd5, 1'b0, 2'd0, 1'b1);
        drain(20);

        // Signed vs unsigned on the same pairs.
        step(1'b1, 16'hFFFF, 16'h0001, 1'b1, 2'd0, 1'b1);
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 2'd0, 1'b1);
        step(1'b1, 16'h8000, 16'h7FFF, 1'b1, 2'd0, 1'b1);
        step(1'b1, 16'h8000, 16'h7FFF, 1'b0, 2'd0, 1'b1);

        // Boundaries through all four OPs.
        all_ops(16'h0000, 16'h0000, 1'b0);
        all_ops(16'hFFFF, 16'hFFFF, 1'b0);
        all_ops(16'h0000, 16'hFFFF, 1'b0);
        all_ops(16'h1230, 16'h1231, 1'b0);
        all_ops(16'h1231, 16'h1230, 1'b1);
        drain(20);

        // 20 back-to-back random pairs at full throughput.
        start_pop = npop;
        for (int i = 0; i < 20; i++)
            step(1'b1, $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF),
                 $urandom_range(0, 1), $urandom_range(0, 3), 1'b1);
        drain(20);
        check("throughput_count", npop - start_pop, 20);

        // Back-pressure: fill the pipe with O_READY low, hold, then release.
        lat_mode = 0;
        for (int i = 0; i < LAT + 5; i++)
            step(1'b1, $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF),
                 $urandom_range(0, 1), $urandom_range(0, 3), 1'b0);
        check("bp_queued", q.size(), LAT);
        drain(20);

        // Random valid/ready traffic with near-equal operands to stress carries.
        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = $urandom_range(0, 16'hFFFF);
            b = ($urandom_range(0, 1) != 0) ? a ^ (16'h1 << $urandom_range(0, 15)) : $urandom_range(0, 16'hFFFF);
            step($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0);
        end
        drain(40);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF), 1'b0, 2'd3, 1'b1);
        I_VALID = 1'b0; RESETN = 1'b0;
        @(posedge CLK); #1;
        cycle++;
        RESETN = 1'b1;
        q.delete();
        held_vld = 0;
        check("midrst_o_valid", O_VALID, 1'b0);
        check("midrst_i_ready", I_READY, 1'b1);
        for (int i = 0; i < LAT + 2; i++) step(1'b0, '0, '0, 1'b0, 2'd0, 1'b1);
        lat_mode = 1;
        step(1'b1, 16'h0042, 16'h0042, 1'b0, 2'd1, 1'b1);
        drain(20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
